// File: rtl/hyperbus_cfg_seq_pkg.sv
// Shared types and default boot table for the HyperBus configuration sequencer.
// The table constants program chip-select ranges and latency before the SoC gets the reg port.
`timescale 1ns/1ps
package hyperbus_cfg_seq_pkg;

    typedef enum logic [2:0] {
        WAIT  = 3'd0,
        WR    = 3'd1,
        RD    = 3'd2,
        NXT   = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } cfg_seq_state_e;

    // Default boot table: latency config, then chip-0/chip-1 address ranges.
    localparam int unsigned HypNumCfgWrites = 4;
    localparam logic [3:0][31:0] HypCfgAddr = {32'h0000_0024, 32'h0000_0020,
                                               32'h0000_001C, 32'h0000_0000};
    localparam logic [3:0][31:0] HypCfgData = {32'h0200_0000, 32'h0100_0000,
                                               32'h0100_0000, 32'h0000_0006};

    function automatic int unsigned cnt_width(int unsigned a, int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m + 1) + 1;
    endfunction

endpackage

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time configuration sequencer and reg-bus arbiter: waits for PHY startup, writes (and
// optionally verifies) a parameter table, then passes the reg port through to the SoC master.
`timescale 1ns/1ps
module hyperbus_cfg_seq
    import hyperbus_cfg_seq_pkg::*;
#(
    parameter int unsigned RegAddrWidth  = 32,
    parameter int unsigned RegDataWidth  = 32,
    parameter int unsigned NumCfgWrites  = 4,
    parameter logic [((NumCfgWrites > 0) ? NumCfgWrites : 1)-1:0][RegAddrWidth-1:0] CfgAddr = '0,
    parameter logic [((NumCfgWrites > 0) ? NumCfgWrites : 1)-1:0][RegDataWidth-1:0] CfgData = '0,
    parameter int unsigned WaitCycles    = 60000,
    parameter bit          ReadBack      = 1'b1,
    parameter int unsigned TimeoutCycles = 1024,
    localparam int unsigned StrbW = RegDataWidth / 8,
    localparam int unsigned IdxW  = $clog2((NumCfgWrites > 2) ? NumCfgWrites : 2)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    restart_i,
    input  logic [RegAddrWidth-1:0] ext_req_addr_i,
    input  logic                    ext_req_write_i,
    input  logic [RegDataWidth-1:0] ext_req_wdata_i,
    input  logic [StrbW-1:0]        ext_req_wstrb_i,
    input  logic                    ext_req_valid_i,
    output logic [RegDataWidth-1:0] ext_rsp_rdata_o,
    output logic                    ext_rsp_ready_o,
    output logic                    ext_rsp_error_o,
    output logic [RegAddrWidth-1:0] cfg_req_addr_o,
    output logic                    cfg_req_write_o,
    output logic [RegDataWidth-1:0] cfg_req_wdata_o,
    output logic [StrbW-1:0]        cfg_req_wstrb_o,
    output logic                    cfg_req_valid_o,
    input  logic [RegDataWidth-1:0] cfg_rsp_rdata_i,
    input  logic                    cfg_rsp_ready_i,
    input  logic                    cfg_rsp_error_i,
    output logic                    done_o,
    output logic                    error_o,
    output logic [IdxW-1:0]         err_idx_o
);

    localparam int unsigned NumEnt = (NumCfgWrites > 0) ? NumCfgWrites : 1;
    localparam int unsigned CntW   = cnt_width(WaitCycles, TimeoutCycles);

    cfg_seq_state_e          state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [IdxW-1:0]         err_idx_q, err_idx_d;
    logic                    pend_q, pend_d;
    logic [RegAddrWidth-1:0] cur_addr;
    logic [RegDataWidth-1:0] cur_data;
    logic                    wait_done, tmo_hit, last_idx;

    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NumEnt; i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_addr = CfgAddr[i];
                cur_data = CfgData[i];
            end
        end
    end

    // The shared counter reads as "cycles already spent" in WAIT and in a stalled WR/RD.
    assign wait_done = (32'(cnt_q) + 32'd1) >= WaitCycles;
    assign tmo_hit   = (TimeoutCycles != 0) && ((32'(cnt_q) + 32'd1) >= TimeoutCycles);
    assign last_idx  = (idx_q == IdxW'(NumEnt - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= WAIT;
            cnt_q     <= '0;
            idx_q     <= '0;
            err_idx_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            pend_q    <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        err_idx_d = err_idx_q;
        pend_d    = pend_q;
        case (state_q)
            WAIT: begin
                cnt_d = cnt_q + CntW'(1);
                if (wait_done) begin
                    cnt_d   = '0;
                    state_d = (NumCfgWrites == 0) ? DONE : WR;
                end
            end
            WR, RD: begin
                if (cfg_rsp_ready_i) begin
                    cnt_d = '0;
                    if (cfg_rsp_error_i ||
                        (state_q == RD && cfg_rsp_rdata_i != cur_data)) begin
                        state_d   = ERROR;
                        err_idx_d = idx_q;
                    end else if (state_q == WR && ReadBack) begin
                        state_d = RD;
                    end else begin
                        state_d = NXT;
                    end
                end else if (tmo_hit) begin
                    cnt_d     = '0;
                    state_d   = ERROR;
                    err_idx_d = idx_q;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            NXT: begin
                if (last_idx) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IdxW'(1);
                    state_d = WR;
                end
            end
            DONE, ERROR: begin
                // Never cut an external transfer that is still holding valid.
                if (pend_q && !ext_req_valid_i) begin
                    state_d   = WAIT;
                    cnt_d     = '0;
                    idx_d     = '0;
                    err_idx_d = '0;
                    pend_d    = 1'b0;
                end else if (restart_i) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        cfg_req_addr_o  = '0;
        cfg_req_write_o = 1'b0;
        cfg_req_wdata_o = '0;
        cfg_req_wstrb_o = '0;
        cfg_req_valid_o = 1'b0;
        ext_rsp_rdata_o = '0;
        ext_rsp_ready_o = 1'b0;
        ext_rsp_error_o = 1'b0;
        case (state_q)
            WR: begin
                cfg_req_addr_o  = cur_addr;
                cfg_req_write_o = 1'b1;
                cfg_req_wdata_o = cur_data;
                cfg_req_wstrb_o = '1;
                cfg_req_valid_o = 1'b1;
            end
            RD: begin
                cfg_req_addr_o  = cur_addr;
                cfg_req_valid_o = 1'b1;
            end
            DONE, ERROR: begin
                cfg_req_addr_o  = ext_req_addr_i;
                cfg_req_write_o = ext_req_write_i;
                cfg_req_wdata_o = ext_req_wdata_i;
                cfg_req_wstrb_o = ext_req_wstrb_i;
                cfg_req_valid_o = ext_req_valid_i;
                ext_rsp_rdata_o = cfg_rsp_rdata_i;
                ext_rsp_ready_o = cfg_rsp_ready_i;
                ext_rsp_error_o = cfg_rsp_error_i;
            end
            default: ;
        endcase
    end

    assign done_o    = (state_q == DONE);
    assign error_o   = (state_q == ERROR);
    assign err_idx_o = err_idx_q;

endmodule
